// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the register-file writeback unit: data width, register index width,
// load funct3 encodings and the load-queue entry layout.
package writeback_unit_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;

   typedef enum logic [2:0] {
      LdB  = 3'b000,
      LdH  = 3'b001,
      LdW  = 3'b010,
      LdBu = 3'b100,
      LdHu = 3'b101
   } ldFunct3E;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic [2:0]       funct3;
      logic [1:0]       ofs;
   } lqEntryT;

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle of ALU, load-issue, memory-return, decode and write-port signals of the writeback unit.
// The writeback unit is the master (it drives the register-file write port).
interface writeback_unit_if #(
   parameter int unsigned XLEN = writeback_unit_pkg::XLEN
);
   logic                                 iALU_VALID;
   logic [writeback_unit_pkg::REG_W-1:0] iALU_RD;
   logic [XLEN-1:0]                      iALU_DATA;
   logic                                 oALU_READY;
   logic                                 iLD_ISSUE;
   logic [writeback_unit_pkg::REG_W-1:0] iLD_RD;
   logic [2:0]                           iLD_FUNCT3;
   logic [1:0]                           iLD_OFS;
   logic                                 oLD_READY;
   logic                                 iMEM_VALID;
   logic [XLEN-1:0]                      iMEM_DATA;
   logic [writeback_unit_pkg::REG_W-1:0] iRS1;
   logic [writeback_unit_pkg::REG_W-1:0] iRS2;
   logic                                 oSTALL;
   logic                                 oWB_VALID;
   logic [writeback_unit_pkg::REG_W-1:0] oWB_RD;
   logic [XLEN-1:0]                      oWB_DATA;
   logic                                 oLQ_UNDERFLOW;

   modport master (
      input  iALU_VALID, iALU_RD, iALU_DATA, iLD_ISSUE, iLD_RD, iLD_FUNCT3, iLD_OFS,
             iMEM_VALID, iMEM_DATA, iRS1, iRS2,
      output oALU_READY, oLD_READY, oSTALL, oWB_VALID, oWB_RD, oWB_DATA, oLQ_UNDERFLOW
   );

   modport slave (
      output iALU_VALID, iALU_RD, iALU_DATA, iLD_ISSUE, iLD_RD, iLD_FUNCT3, iLD_OFS,
             iMEM_VALID, iMEM_DATA, iRS1, iRS2,
      input  oALU_READY, oLD_READY, oSTALL, oWB_VALID, oWB_RD, oWB_DATA, oLQ_UNDERFLOW
   );

endinterface

// File: rtl/writeback_unit_load_extend.sv
// Selects the byte/halfword lane of a returned memory word and sign- or zero-extends it.
module load_extend
   import writeback_unit_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      ofs,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] data
);

   logic [7:0]  byteLane;
   logic [15:0] halfLane;

   always_comb begin
      case (ofs)
         2'd0:    byteLane = word[7:0];
         2'd1:    byteLane = word[15:8];
         2'd2:    byteLane = word[23:16];
         default: byteLane = word[31:24];
      endcase
      // Halfword accesses are assumed aligned, so only ofs[1] picks the lane.
      halfLane = ofs[1] ? word[31:16] : word[15:0];

      data = word;
      case (funct3)
         LdB:     data = {{(XLEN-8){byteLane[7]}}, byteLane};
         LdH:     data = {{(XLEN-16){halfLane[15]}}, halfLane};
         LdBu:    data = {{(XLEN-8){1'b0}}, byteLane};
         LdHu:    data = {{(XLEN-16){1'b0}}, halfLane};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write-side master: arbitrates ALU results against in-order load returns and
// tracks pending load destinations so decode can stall on them.
module writeback_unit #(
   parameter int unsigned LQ_DEPTH = 2,
   parameter int unsigned XLEN     = writeback_unit_pkg::XLEN
) (
   input logic              iCLK,
   input logic              iRST,
   writeback_unit_if.master bus
);
   import writeback_unit_pkg::*;

   localparam int unsigned PtrW = $clog2(LQ_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   lqEntryT lqMem [LQ_DEPTH];

   logic [PtrW-1:0]  headQ, headD, tailQ, tailD;
   logic [CntW-1:0]  countQ, countD;
   logic [31:0]      pendQ, pendD;
   logic             lqEmpty, lqFull, memPop, ldPush, ldBlocked, ldReady;
   lqEntryT          headEntry, newEntry;
   logic [XLEN-1:0]  ldData;

   logic             wbValidQ, wbValidD, underQ, underD;
   logic [REG_W-1:0] wbRdQ, wbRdD;
   logic [XLEN-1:0]  wbDataQ, wbDataD;

   load_extend uExtend (
      .funct3 (headEntry.funct3),
      .ofs    (headEntry.ofs),
      .word   (bus.iMEM_DATA),
      .data   (ldData)
   );

   always_comb begin
      lqEmpty   = (countQ == '0);
      lqFull    = (countQ == CntW'(LQ_DEPTH));
      headEntry = lqMem[headQ];
      memPop    = bus.iMEM_VALID && !lqEmpty;
      ldBlocked = (bus.iLD_RD != '0) && pendQ[bus.iLD_RD];
      // A same-cycle return frees a slot, so a full queue can still accept an issue.
      ldReady   = (!lqFull || memPop) && !ldBlocked;
      ldPush    = bus.iLD_ISSUE && ldReady;
      newEntry  = '{rd: bus.iLD_RD, funct3: bus.iLD_FUNCT3, ofs: bus.iLD_OFS};

      headD  = headQ + PtrW'(memPop);
      tailD  = tailQ + PtrW'(ldPush);
      countD = countQ + CntW'(ldPush) - CntW'(memPop);

      // Clear before set so a same-cycle reissue to the returning rd stays pending.
      pendD = pendQ;
      if (memPop) pendD[headEntry.rd] = 1'b0;
      if (ldPush && (bus.iLD_RD != '0)) pendD[bus.iLD_RD] = 1'b1;

      wbValidD = 1'b0;
      wbRdD    = '0;
      wbDataD  = '0;
      if (memPop) begin
         wbValidD = 1'b1;
         wbRdD    = headEntry.rd;
         wbDataD  = ldData;
      end else if (bus.iALU_VALID) begin
         wbValidD = 1'b1;
         wbRdD    = bus.iALU_RD;
         wbDataD  = bus.iALU_DATA;
      end
      underD = bus.iMEM_VALID && lqEmpty;
   end

   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         headQ    <= '0;
         tailQ    <= '0;
         countQ   <= '0;
         pendQ    <= '0;
         wbValidQ <= 1'b0;
         wbRdQ    <= '0;
         wbDataQ  <= '0;
         underQ   <= 1'b0;
      end else begin
         headQ    <= headD;
         tailQ    <= tailD;
         countQ   <= countD;
         pendQ    <= pendD;
         wbValidQ <= wbValidD;
         wbRdQ    <= wbRdD;
         wbDataQ  <= wbDataD;
         underQ   <= underD;
      end
   end

   always_ff @(posedge iCLK) begin
      if (ldPush) lqMem[tailQ] <= newEntry;
   end

   assign bus.oALU_READY    = !memPop;
   assign bus.oLD_READY     = ldReady;
   assign bus.oSTALL        = ((bus.iRS1 != '0) && pendQ[bus.iRS1]) ||
                              ((bus.iRS2 != '0) && pendQ[bus.iRS2]);
   assign bus.oWB_VALID     = wbValidQ;
   assign bus.oWB_RD        = wbRdQ;
   assign bus.oWB_DATA      = wbDataQ;
   assign bus.oLQ_UNDERFLOW = underQ;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_writeback_unit;

   localparam int unsigned LQ_DEPTH = 2;

   logic iCLK = 1'b0;
   logic iRST = 1'b0;
   always #5 iCLK = ~iCLK;

   writeback_unit_if #(.XLEN(32)) bus ();

   writeback_unit #(.LQ_DEPTH(LQ_DEPTH), .XLEN(32)) dut (
      .iCLK (iCLK),
      .iRST (iRST),
      .bus  (bus)
   );

   typedef struct { int rd; int f3; int ofs; } ldT;

   ldT          mq[$];
   bit          mPend [32];
   int          nCmp = 0;
   int          nErr = 0;
   bit          eAluReady, eLdReady, eStall, eWbValid, eUnder;
   int          eWbRd;
   logic [31:0] eWbData;

   function automatic logic [31:0] mExt(int f3, int ofs, logic [31:0] w);
      int unsigned wu = w;
      int unsigned b  = (wu >> (8 * ofs)) % 256;
      int unsigned h  = (wu >> (16 * (ofs / 2))) % 65536;
      case (f3)
         0:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         1:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         4:       return b;
         5:       return h;
         default: return w;
      endcase
   endfunction

   function automatic void predict();
      bit pop = bus.iMEM_VALID && (mq.size() > 0);
      eAluReady = !pop;
      eLdReady  = ((mq.size() < LQ_DEPTH) || pop) && !((bus.iLD_RD != 0) && mPend[bus.iLD_RD]);
      eStall    = ((bus.iRS1 != 0) && mPend[bus.iRS1]) || ((bus.iRS2 != 0) && mPend[bus.iRS2]);
   endfunction

   task automatic tick();
      ldT h;
      bit pop, acc;
      predict();
      pop = bus.iMEM_VALID && (mq.size() > 0);
      acc = bus.iLD_ISSUE && eLdReady;
      if (!iRST) begin
         mq.delete();
         for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
         eWbValid = 0; eWbRd = 0; eWbData = '0; eUnder = 0;
      end else begin
         eUnder = bus.iMEM_VALID && (mq.size() == 0);
         if (pop) begin
            h = mq.pop_front();
            eWbValid = 1; eWbRd = h.rd; eWbData = mExt(h.f3, h.ofs, bus.iMEM_DATA);
            mPend[h.rd] = 1'b0;
         end else if (bus.iALU_VALID) begin
            eWbValid = 1; eWbRd = int'(bus.iALU_RD); eWbData = bus.iALU_DATA;
         end else begin
            eWbValid = 0; eWbRd = 0; eWbData = '0;
         end
         if (acc) begin
            mq.push_back('{rd: int'(bus.iLD_RD), f3: int'(bus.iLD_FUNCT3), ofs: int'(bus.iLD_OFS)});
            if (bus.iLD_RD != 0) mPend[bus.iLD_RD] = 1'b1;
         end
      end
      @(posedge iCLK);
      #1;
   endtask

   task automatic idle();
      bus.iALU_VALID = 0; bus.iALU_RD = '0; bus.iALU_DATA = '0;
      bus.iLD_ISSUE = 0; bus.iLD_RD = '0; bus.iLD_FUNCT3 = '0; bus.iLD_OFS = '0;
      bus.iMEM_VALID = 0; bus.iMEM_DATA = '0; bus.iRS1 = '0; bus.iRS2 = '0;
   endtask

   task automatic issue(int rd, int f3, int ofs);
      bus.iLD_ISSUE = 1; bus.iLD_RD = 5'(rd); bus.iLD_FUNCT3 = 3'(f3); bus.iLD_OFS = 2'(ofs);
   endtask

   task automatic test_reset();
      idle();
      iRST = 0;
      tick(); tick();
      iRST = 1;
      nCmp++; if ({bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA, bus.oLQ_UNDERFLOW} !== '0) begin
         nErr++; $display("FAIL reset_outputs: got v=%b rd=%0d d=%h u=%b want all 0",
                          bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA, bus.oLQ_UNDERFLOW);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         nCmp++; if ({bus.oWB_VALID, bus.oWB_RD, bus.oSTALL} !== '0) begin
            nErr++; $display("FAIL idle_cycle%0d: got v=%b rd=%0d stall=%b want 0 0 0",
                             i, bus.oWB_VALID, bus.oWB_RD, bus.oSTALL);
         end
      end
   endtask

   task automatic test_alu();
      idle();
      bus.iALU_VALID = 1; bus.iALU_RD = 5'd5; bus.iALU_DATA = 32'h1234_5678;
      #1;
      nCmp++; if (bus.oALU_READY !== 1'b1) begin
         nErr++; $display("FAIL alu_ready: got %b want 1", bus.oALU_READY);
      end
      tick();
      nCmp++; if ({bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA} !== {1'b1, 5'd5, 32'h1234_5678}) begin
         nErr++; $display("FAIL alu_write: got v=%b rd=%0d d=%h want 1 5 12345678",
                          bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA);
      end
      for (int i = 0; i < 16; i++) begin
         bus.iALU_VALID = 1'($urandom_range(0, 3) != 0);
         bus.iALU_RD = 5'($urandom_range(0, 31)); bus.iALU_DATA = $urandom;
         tick();
         nCmp++; if ({bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA} !== {eWbValid, 5'(eWbRd), eWbData}) begin
            nErr++; $display("FAIL alu_rand%0d: got v=%b rd=%0d d=%h want v=%b rd=%0d d=%h", i,
                             bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA, eWbValid, eWbRd, eWbData);
         end
      end
      idle(); tick();
   endtask

   task automatic test_load_ext();
      int          f3T [3] = '{0, 4, 1};
      logic [31:0] wT  [3] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_FFFF};
      logic [31:0] xT  [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
      for (int i = 0; i < 3; i++) begin
         idle(); issue(3, f3T[i], 2); tick();
         idle(); bus.iMEM_VALID = 1; bus.iMEM_DATA = wT[i]; tick();
         nCmp++; if ({bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA} !== {1'b1, 5'd3, xT[i]}) begin
            nErr++; $display("FAIL ext_dir%0d: got v=%b rd=%0d d=%h want 1 3 %h", i,
                             bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA, xT[i]);
         end
      end
      for (int i = 0; i < 24; i++) begin
         idle(); issue($urandom_range(1, 31), $urandom_range(0, 7), $urandom_range(0, 3)); tick();
         idle(); bus.iMEM_VALID = 1; bus.iMEM_DATA = $urandom; tick();
         nCmp++; if ({bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA} !== {eWbValid, 5'(eWbRd), eWbData}) begin
            nErr++; $display("FAIL ext_rand%0d: got v=%b rd=%0d d=%h want v=%b rd=%0d d=%h", i,
                             bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA, eWbValid, eWbRd, eWbData);
         end
      end
      idle(); tick();
   endtask

   task automatic test_hazard();
      logic [31:0] w = $urandom;
      logic [31:0] a = $urandom;
      idle(); issue(7, 2, 0); bus.iRS1 = 5'd7; tick();
      bus.iLD_ISSUE = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         nCmp++; if (bus.oSTALL !== 1'b1) begin
            nErr++; $display("FAIL haz_stall%0d: got %b want 1", i, bus.oSTALL);
         end
         tick();
      end
      bus.iMEM_VALID = 1; bus.iMEM_DATA = w;
      bus.iALU_VALID = 1; bus.iALU_RD = 5'd9; bus.iALU_DATA = a;
      #1;
      nCmp++; if (bus.oALU_READY !== 1'b0) begin
         nErr++; $display("FAIL haz_alu_ready: got %b want 0", bus.oALU_READY);
      end
      tick();
      nCmp++; if ({bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA} !== {1'b1, 5'd7, w}) begin
         nErr++; $display("FAIL haz_load_first: got v=%b rd=%0d d=%h want 1 7 %h",
                          bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA, w);
      end
      bus.iMEM_VALID = 0;
      #1;
      nCmp++; if ({bus.oALU_READY, bus.oSTALL} !== 2'b10) begin
         nErr++; $display("FAIL haz_release: got ready=%b stall=%b want 1 0",
                          bus.oALU_READY, bus.oSTALL);
      end
      tick();
      nCmp++; if ({bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA} !== {1'b1, 5'd9, a}) begin
         nErr++; $display("FAIL haz_alu_second: got v=%b rd=%0d d=%h want 1 9 %h",
                          bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA, a);
      end
      idle(); tick();
   endtask

   task automatic test_full_waw();
      // Each step: {issue rd, return?, expected oLD_READY}; queue starts holding rd1, rd2.
      int rdT  [6] = '{3, 1, 2, 4, 5, 6};
      bit retT [6] = '{0, 1, 0, 1, 0, 1};
      bit rdyT [6] = '{0, 0, 0, 1, 1, 1};
      idle(); issue(1, 2, 0); tick(); issue(2, 2, 0); tick();
      for (int i = 0; i < 6; i++) begin
         idle(); issue(rdT[i], 2, 0);
         bus.iMEM_VALID = retT[i]; bus.iMEM_DATA = $urandom;
         #1;
         nCmp++; if (bus.oLD_READY !== rdyT[i]) begin
            nErr++; $display("FAIL full_ready%0d: got %b want %b", i, bus.oLD_READY, rdyT[i]);
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         idle(); bus.iMEM_VALID = 1; bus.iMEM_DATA = $urandom; tick();
         nCmp++; if ({bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA} !== {1'b1, 5'(5 + i), eWbData}) begin
            nErr++; $display("FAIL full_drain%0d: got v=%b rd=%0d d=%h want 1 %0d %h", i,
                             bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA, 5 + i, eWbData);
         end
      end
      idle(); tick();
   endtask

   task automatic test_underflow_reset();
      idle(); bus.iMEM_VALID = 1; bus.iMEM_DATA = 32'hDEAD_BEEF;
      #1;
      nCmp++; if (bus.oALU_READY !== 1'b1) begin
         nErr++; $display("FAIL under_alu_ready: got %b want 1", bus.oALU_READY);
      end
      tick();
      nCmp++; if ({bus.oLQ_UNDERFLOW, bus.oWB_VALID} !== 2'b10) begin
         nErr++; $display("FAIL under_pulse: got u=%b v=%b want 1 0",
                          bus.oLQ_UNDERFLOW, bus.oWB_VALID);
      end
      idle(); tick();
      nCmp++; if (bus.oLQ_UNDERFLOW !== 1'b0) begin
         nErr++; $display("FAIL under_one_cycle: got %b want 0", bus.oLQ_UNDERFLOW);
      end
      issue(11, 2, 0); tick(); issue(12, 2, 0); tick();
      bus.iLD_ISSUE = 0; bus.iRS1 = 5'd11; bus.iRS2 = 5'd12;
      #1;
      nCmp++; if (bus.oSTALL !== 1'b1) begin
         nErr++; $display("FAIL rst_pre_stall: got %b want 1", bus.oSTALL);
      end
      iRST = 0; tick(); iRST = 1;
      #1;
      nCmp++; if ({bus.oSTALL, bus.oLD_READY} !== 2'b01) begin
         nErr++; $display("FAIL rst_cleared: got stall=%b ldready=%b want 0 1",
                          bus.oSTALL, bus.oLD_READY);
      end
      bus.iMEM_VALID = 1; bus.iMEM_DATA = $urandom; tick();
      nCmp++; if ({bus.oLQ_UNDERFLOW, bus.oWB_VALID} !== 2'b10) begin
         nErr++; $display("FAIL rst_underflow: got u=%b v=%b want 1 0",
                          bus.oLQ_UNDERFLOW, bus.oWB_VALID);
      end
      idle(); tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if (!(bus.iALU_VALID && !eAluReady)) begin
            bus.iALU_VALID = 1'($urandom_range(0, 1));
            bus.iALU_RD = 5'($urandom_range(0, 31)); bus.iALU_DATA = $urandom;
         end
         bus.iLD_ISSUE = 1'($urandom_range(0, 2) == 0);
         bus.iLD_RD = 5'($urandom_range(0, 7)); bus.iLD_FUNCT3 = 3'($urandom_range(0, 7));
         bus.iLD_OFS = 2'($urandom_range(0, 3));
         bus.iMEM_VALID = (mq.size() > 0) ? 1'($urandom_range(0, 2) != 0)
                                          : 1'($urandom_range(0, 9) == 0);
         bus.iMEM_DATA = $urandom;
         bus.iRS1 = 5'($urandom_range(0, 7)); bus.iRS2 = 5'($urandom_range(0, 7));
         #1;
         predict();
         nCmp++; if ({bus.oALU_READY, bus.oLD_READY, bus.oSTALL} !== {eAluReady, eLdReady, eStall}) begin
            nErr++; $display("FAIL rand_comb%0d: got ar=%b lr=%b st=%b want %b %b %b", i,
                             bus.oALU_READY, bus.oLD_READY, bus.oSTALL, eAluReady, eLdReady, eStall);
         end
         tick();
         nCmp++; if ({bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA, bus.oLQ_UNDERFLOW} !==
                     {eWbValid, 5'(eWbRd), eWbData, eUnder}) begin
            nErr++; $display("FAIL rand_wb%0d: got v=%b rd=%0d d=%h u=%b want v=%b rd=%0d d=%h u=%b",
                             i, bus.oWB_VALID, bus.oWB_RD, bus.oWB_DATA, bus.oLQ_UNDERFLOW,
                             eWbValid, eWbRd, eWbData, eUnder);
         end
      end
      idle(); tick();
   endtask

   initial begin
      idle();
      test_reset();
      test_alu();
      test_load_ext();
      test_hazard();
      test_full_waw();
      test_underflow_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
